product_accumulator: RTL



---
 rtl/mult_pkg.sv | 19 +
 rtl/sat_adder.sv | 19 +
 rtl/product_accumulator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath and its downstream accumulation stages.
package mult_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 12;
    localparam int COUNT_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Sample counter must be able to hold COUNT itself.
    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Unsigned adder that clamps to all-ones on carry out and reports the clamp.
module sat_adder #(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);

    logic [ACC_W:0] sum_wide;

    always_comb begin
        sum_wide = {1'b0, a} + {1'b0, b};
        overflow = sum_wide[ACC_W];
        sum      = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums frames of COUNT multiplier products into a saturating total with valid/ready on both sides.
//
// state    | meaning
// ST_IDLE  | no sample of the current frame accepted yet
// ST_ACCUM | 1..COUNT-1 samples accepted
// ST_HOLD  | frame total presented, waiting for out_ready
module product_accumulator
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int COUNT  = COUNT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              busy
);

    localparam int            CW       = cnt_width(COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CW-1:0]     cnt;
    logic              acc_ovf;

    logic              accept;
    logic [CW-1:0]     cnt_nxt;
    logic [ACC_W-1:0]  add_a;
    logic [ACC_W-1:0]  add_b;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic              ovf_nxt;

    assign in_ready = !clear && (state != ST_HOLD);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);
    assign cnt_nxt  = cnt + CW'(1);

    // Starting a frame adds into zero, so IDLE and ACCUM share the adder path.
    assign add_a   = (state == ST_IDLE) ? '0 : acc;
    assign add_b   = ACC_W'(in_product);
    assign ovf_nxt = acc_ovf | add_ovf;

    sat_adder #(
        .ACC_W(ACC_W)
    ) u_sat_adder (
        .a        (add_a),
        .b        (add_b),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            acc          <= '0;
            cnt          <= '0;
            acc_ovf      <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else if (clear) begin
            state        <= ST_IDLE;
            acc          <= '0;
            cnt          <= '0;
            acc_ovf      <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc     <= add_sum;
                        cnt     <= cnt_nxt;
                        acc_ovf <= ovf_nxt;
                        if (cnt_nxt == CNT_LAST) begin
                            state        <= ST_HOLD;
                            out_valid    <= 1'b1;
                            out_sum      <= add_sum;
                            out_overflow <= ovf_nxt;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state        <= ST_IDLE;
                        acc          <= '0;
                        cnt          <= '0;
                        acc_ovf      <= 1'b0;
                        out_valid    <= 1'b0;
                        out_sum      <= '0;
                        out_overflow <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    acc          <= '0;
                    cnt          <= '0;
                    acc_ovf      <= 1'b0;
                    out_valid    <= 1'b0;
                    out_sum      <= '0;
                    out_overflow <= 1'b0;
                end
            endcase
        end
    end

endmodule
